sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single off-chip 16-bit SRAM between two requesters.
  - Port 0: the SLC-3 CPU memory path (MAR/MDR sequencing driven by the ISDU).
  - Port 1: a secondary master (program loader / debug DMA).
- Converts a level request/done handshake into correctly timed active-low SRAM strobes with a fixed multi-cycle access window and a recovery cycle.
- Sits between the CPU/loader and the top-level tri-state SRAM pad logic.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- ACCESS_CYCLES, 2, cycles OE_N/WE_N are held low per access (legal range 1..15).
- CPU_PRIORITY, 0, 1 = port 0 always wins ties; 0 = round-robin on ties.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous active-high reset
- Req0  in  1  port 0 request, held high until Done0
- We0  in  1  port 0 write (1) / read (0)
- Addr0  in  ADDR_W  port 0 address
- WData0  in  DATA_W  port 0 write data
- Gnt0  out  1  port 0 owns SRAM (ACCESS and RECOVER)
- Done0  out  1  one-cycle completion pulse, port 0
- RData0  out  DATA_W  port 0 read data, valid when Done0=1 and held until next port 0 read
- Req1, We1, Addr1, WData1, Gnt1, Done1, RData1  same meaning, port 1
- Mem_CE_N  out  1  chip enable, active low
- Mem_UB_N  out  1  upper byte enable, active low
- Mem_LB_N  out  1  lower byte enable, active low
- Mem_OE_N  out  1  output enable, active low
- Mem_WE_N  out  1  write enable, active low
- Mem_Addr  out  ADDR_W  registered SRAM address
- Mem_DOut  out  DATA_W  registered write data to pad
- Mem_DOE  out  1  pad drive enable, high only during write ACCESS cycles
- Mem_DIn  in  DATA_W  data from pad

Behaviour:
- Clk and Reset: reset Reset, synchronous, active-high; clock Clk.
- Reset values:
  - State = IDLE, counter = 0, last_grant = 1.
  - All *_N outputs = 1; Gnt*/Done*/Mem_DOE = 0.
  - Mem_Addr, Mem_DOut, RData0, RData1 = 0.
- States: IDLE, ACCESS, RECOVER.
- IDLE:
  - No request: stay in IDLE, all strobes high.
  - Any Req high: pick a winner, latch its We/Addr/WData into We_q/Mem_Addr/Mem_DOut, go to ACCESS, counter = ACCESS_CYCLES-1.
- Winner selection:
  - Only one Req high: that port wins.
  - Both high, CPU_PRIORITY=1: port 0 wins.
  - Both high, CPU_PRIORITY=0: the port not equal to last_grant wins. After reset, port 0 wins the first tie.
  - last_grant is updated to the winner on entry to ACCESS.
- ACCESS:
  - Mem_CE_N, Mem_UB_N, Mem_LB_N = 0.
  - Read: Mem_OE_N = 0.
  - Write: Mem_WE_N = 0, Mem_DOE = 1.
  - Counter decrements each cycle. When it reaches 0, go to RECOVER.
  - Read with counter 0: register Mem_DIn into the winner's RData on that edge.
- RECOVER:
  - All strobes high, Mem_DOE = 0.
  - Winner's Done = 1 for exactly this cycle.
  - Next state = IDLE.
- Gnt of the winner is high in ACCESS and RECOVER, low otherwise. Gnt0 and Gnt1 are never both high.
- Latency: Req sampled high in IDLE at cycle t gives ACCESS cycles t+1..t+ACCESS_CYCLES and Done at t+ACCESS_CYCLES+1. Minimum spacing between accesses is ACCESS_CYCLES+2 cycles.
- Handshake:
  - Requester keeps Req, We, Addr and WData stable until Done, then drops Req on the next cycle.
  - Req still high in the IDLE cycle after RECOVER counts as a new request.
  - Changes to Addr/WData/We after grant are ignored; the values are latched.
  - Req dropped during ACCESS does not abort the access: it completes and Done still pulses.
- Starvation: with CPU_PRIORITY=0 and both ports requesting back-to-back, grants strictly alternate.
- Reset mid-operation (ACCESS or RECOVER): next edge returns to IDLE. Strobes are high and Mem_DOE is 0 from that edge on. No Done is issued. Partial RData is not updated.
- Mem_Addr and Mem_DOut hold their last latched value outside ACCESS.

Decomposition:
- Package sram_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, ACCESS, RECOVER}
  - ADDR_W/DATA_W default constants
  - localparam PORT_CPU = 0, PORT_AUX = 1
- Sub-module sram_arb_pick: 2-way winner select from Req0, Req1, last_grant and CPU_PRIORITY. Combinational, single instance.
- FSM, counter and latches stay in sram_arbiter.

Test Plan:
- Single read, port 0, ACCESS_CYCLES=2, SRAM model returns 16'hBEEF at Addr0=20'h00010:
  - Req0 at t0 → Mem_OE_N=0 at t1–t2, Done0=1 only at t3, RData0=16'hBEEF, Gnt1 never high.
- Single write, port 1, Addr1=20'h0FFFF, WData1=16'h1234:
  - Mem_WE_N=0 and Mem_DOE=1 for exactly 2 cycles, Mem_Addr=20'h0FFFF, Mem_DOut=16'h1234, Mem_OE_N stays 1.
  - Read-back via port 0 returns 16'h1234.
- Tie, CPU_PRIORITY=0, Req0 and Req1 held continuously:
  - Grants are port0, port1, port0, port1, with Done pulses 4 cycles apart.
  - With CPU_PRIORITY=1: port0 is granted every time.
- Latching, port 0 read of Addr0=20'h00020 (memory 16'h00AA) with Addr0 changed to 20'h00040 one cycle after grant:
  - Mem_Addr stays 20'h00020 throughout ACCESS; RData0 = memory[20'h00020] = 16'h00AA.
- Reset asserted in first ACCESS cycle of a write:
  - Next cycle Mem_WE_N=1, Mem_DOE=0, state IDLE, no Done.
  - Memory location unchanged if the model commits on WE_N rising after a full window.
- ACCESS_CYCLES=1 parameterisation, single port 0 read:
  - Done at t0+2 after Req at t0.
  - Back-to-back requests from one port spaced 3 cycles apart.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port off-chip SRAM arbiter.
package sram_arb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } arb_state_t;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;
endpackage

// File: rtl/sram_arb_pick.sv
// Two-way winner select: single request wins outright, ties go to the CPU
// port or alternate against the previous grant.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int CPU_PRIORITY = 0
) (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_any,
    output logic o_win
);
    assign o_any = i_req0 | i_req1;

    always_comb begin
        o_win = PORT_CPU;
        if (i_req0 && i_req1)
            o_win = (CPU_PRIORITY != 0) ? PORT_CPU : ~i_last_grant;
        else if (i_req1)
            o_win = PORT_AUX;
    end
endmodule

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between the CPU memory path and an auxiliary master,
// producing active-low strobes with a fixed access window and a recovery cycle.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = SRAM_ADDR_W,
    parameter int DATA_W        = SRAM_DATA_W,
    parameter int ACCESS_CYCLES = 2,
    parameter int CPU_PRIORITY  = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    output logic              Gnt0,
    output logic              Done0,
    output logic [DATA_W-1:0] RData0,
    input  logic              Req1,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Gnt1,
    output logic              Done1,
    output logic [DATA_W-1:0] RData1,
    output logic              Mem_CE_N,
    output logic              Mem_UB_N,
    output logic              Mem_LB_N,
    output logic              Mem_OE_N,
    output logic              Mem_WE_N,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_DOut,
    output logic              Mem_DOE,
    input  logic [DATA_W-1:0] Mem_DIn
);
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    arb_state_t r_state;
    logic [3:0] r_cnt;
    logic       r_last;   // last granted port; doubles as the current owner
    logic       r_we;
    logic       w_any, w_win, w_acc, w_busy, w_rec;

    sram_arb_pick #(.CPU_PRIORITY(CPU_PRIORITY)) u_pick (
        .i_req0       (Req0),
        .i_req1       (Req1),
        .i_last_grant (r_last),
        .o_any        (w_any),
        .o_win        (w_win)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_last   <= PORT_AUX;
            r_we     <= 1'b0;
            Mem_Addr <= '0;
            Mem_DOut <= '0;
            RData0   <= '0;
            RData1   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_state  <= ACCESS;
                    r_cnt    <= CNT_LOAD;
                    r_last   <= w_win;
                    r_we     <= w_win ? We1    : We0;
                    Mem_Addr <= w_win ? Addr1  : Addr0;
                    Mem_DOut <= w_win ? WData1 : WData0;
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RECOVER;
                        // Sample read data on the last edge of the window.
                        if (!r_we) begin
                            if (r_last) RData1 <= Mem_DIn;
                            else        RData0 <= Mem_DIn;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RECOVER: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_acc  = (r_state == ACCESS);
    assign w_rec  = (r_state == RECOVER);
    assign w_busy = w_acc | w_rec;

    assign Gnt0     = w_busy & ~r_last;
    assign Gnt1     = w_busy &  r_last;
    assign Done0    = w_rec  & ~r_last;
    assign Done1    = w_rec  &  r_last;
    assign Mem_CE_N = ~w_acc;
    assign Mem_UB_N = ~w_acc;
    assign Mem_LB_N = ~w_acc;
    assign Mem_OE_N = ~(w_acc & ~r_we);
    assign Mem_WE_N = ~(w_acc &  r_we);
    assign Mem_DOE  = w_acc & r_we;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: round-robin main instance with an SRAM model, plus a
// CPU-priority instance and an ACCESS_CYCLES=1 instance sharing clock/reset.
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // ---------------- main instance (ACCESS_CYCLES=2, round robin)
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [19:0] addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, done0, gnt1, done1;
    logic [15:0] rdata0, rdata1;
    logic        ce_n, ub_n, lb_n, oe_n, we_n, doe;
    logic [19:0] m_addr;
    logic [15:0] m_dout, m_din;

    sram_arbiter #(.ACCESS_CYCLES(2), .CPU_PRIORITY(0)) u_rr (
        .Clk(clk), .Reset(rst),
        .Req0(req0), .We0(we0), .Addr0(addr0), .WData0(wdata0),
        .Gnt0(gnt0), .Done0(done0), .RData0(rdata0),
        .Req1(req1), .We1(we1), .Addr1(addr1), .WData1(wdata1),
        .Gnt1(gnt1), .Done1(done1), .RData1(rdata1),
        .Mem_CE_N(ce_n), .Mem_UB_N(ub_n), .Mem_LB_N(lb_n),
        .Mem_OE_N(oe_n), .Mem_WE_N(we_n),
        .Mem_Addr(m_addr), .Mem_DOut(m_dout), .Mem_DOE(doe), .Mem_DIn(m_din)
    );

    // SRAM model: a write commits on WE_N rising only after a full 2-cycle window.
    logic [15:0] mem [0:65535];
    int          wcnt = 0;
    logic [15:0] waddr = '0, wdat = '0;
    assign m_din = mem[m_addr[15:0]];

    always @(posedge clk) begin
        if (!we_n) begin
            wcnt  <= wcnt + 1;
            waddr <= m_addr[15:0];
            wdat  <= m_dout;
        end else begin
            if (wcnt == 2) mem[waddr] <= wdat;
            wcnt <= 0;
        end
    end

    // ---------------- CPU_PRIORITY=1 instance, both requests held high
    logic        p_req = 1'b1;
    logic        p_gnt0, p_gnt1, p_done0, p_done1, p_ce, p_ub, p_lb, p_oe, p_we, p_doe;
    logic [15:0] p_rd0, p_rd1, p_dout;
    logic [19:0] p_addr;

    sram_arbiter #(.ACCESS_CYCLES(2), .CPU_PRIORITY(1)) u_pri (
        .Clk(clk), .Reset(rst),
        .Req0(p_req), .We0(1'b0), .Addr0(20'h0), .WData0(16'h0),
        .Gnt0(p_gnt0), .Done0(p_done0), .RData0(p_rd0),
        .Req1(p_req), .We1(1'b0), .Addr1(20'h0), .WData1(16'h0),
        .Gnt1(p_gnt1), .Done1(p_done1), .RData1(p_rd1),
        .Mem_CE_N(p_ce), .Mem_UB_N(p_ub), .Mem_LB_N(p_lb),
        .Mem_OE_N(p_oe), .Mem_WE_N(p_we),
        .Mem_Addr(p_addr), .Mem_DOut(p_dout), .Mem_DOE(p_doe), .Mem_DIn(16'h0)
    );

    // ---------------- ACCESS_CYCLES=1 instance, read data = addr ^ 5A5A
    logic        a_req0 = 1'b0;
    logic        a_gnt0, a_gnt1, a_done0, a_done1, a_ce, a_ub, a_lb, a_oe, a_we, a_doe;
    logic [15:0] a_rd0, a_rd1, a_dout, a_din;
    logic [19:0] a_addr;
    assign a_din = a_addr[15:0] ^ 16'h5A5A;

    sram_arbiter #(.ACCESS_CYCLES(1), .CPU_PRIORITY(0)) u_a1 (
        .Clk(clk), .Reset(rst),
        .Req0(a_req0), .We0(1'b0), .Addr0(20'h00007), .WData0(16'h0),
        .Gnt0(a_gnt0), .Done0(a_done0), .RData0(a_rd0),
        .Req1(1'b0), .We1(1'b0), .Addr1(20'h0), .WData1(16'h0),
        .Gnt1(a_gnt1), .Done1(a_done1), .RData1(a_rd1),
        .Mem_CE_N(a_ce), .Mem_UB_N(a_ub), .Mem_LB_N(a_lb),
        .Mem_OE_N(a_oe), .Mem_WE_N(a_we),
        .Mem_Addr(a_addr), .Mem_DOut(a_dout), .Mem_DOE(a_doe), .Mem_DIn(a_din)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0020] = 16'h00AA;
        mem[16'h0040] = 16'h5555;

        // Reset state
        tick(); tick();
        chk("rst_ce_n", ce_n, 1); chk("rst_oe_n", oe_n, 1); chk("rst_we_n", we_n, 1);
        chk("rst_ublb", {ub_n, lb_n}, 2'b11);
        chk("rst_gnt", {gnt0, gnt1}, 0); chk("rst_done", {done0, done1}, 0);
        chk("rst_doe", doe, 0); chk("rst_addr", m_addr, 0);
        chk("rst_dout", m_dout, 0); chk("rst_rdata", {rdata0, rdata1}, 0);
        rst = 1'b0;

        // Single read, port 0
        req0 = 1; we0 = 0; addr0 = 20'h00010;
        tick(); chk("rd_t1_oe", oe_n, 0); chk("rd_t1_ce", ce_n, 0); chk("rd_t1_gnt", {gnt0, gnt1}, 2'b10);
        chk("rd_t1_done", done0, 0);
        tick(); chk("rd_t2_oe", oe_n, 0); chk("rd_t2_gnt1", gnt1, 0); chk("rd_t2_done", done0, 0);
        tick(); chk("rd_t3_done", done0, 1); chk("rd_t3_oe", oe_n, 1); chk("rd_t3_rdata", rdata0, 16'hBEEF);
        chk("rd_t3_gnt1", gnt1, 0);
        req0 = 0;
        tick(); chk("rd_t4_done", done0, 0); chk("rd_t4_gnt", {gnt0, gnt1}, 0);

        // Single write, port 1
        req1 = 1; we1 = 1; addr1 = 20'h0FFFF; wdata1 = 16'h1234;
        tick(); chk("wr_t1", {we_n, doe, oe_n, gnt1}, 4'b0111);
        chk("wr_addr", m_addr, 20'h0FFFF); chk("wr_dout", m_dout, 16'h1234);
        tick(); chk("wr_t2", {we_n, doe, oe_n, gnt1}, 4'b0111);
        tick(); chk("wr_t3", {we_n, doe, oe_n, done1}, 4'b1011);
        req1 = 0; we1 = 0;
        tick();
        req0 = 1; addr0 = 20'h0FFFF;
        tick(); tick(); tick();
        chk("wr_rb_done", done0, 1); chk("wr_rb_rdata", rdata0, 16'h1234);
        req0 = 0;
        tick();

        // Tie: round robin on u_rr, fixed priority on u_pri
        rst = 1; tick(); rst = 0;
        req0 = 1; addr0 = 20'h00010; req1 = 1; we1 = 0; addr1 = 20'h00020;
        for (int k = 0; k < 4; k++) begin
            logic ew;
            ew = k[0];
            tick();
            chk("tie_gnt", {gnt0, gnt1}, {~ew, ew});
            chk("pri_gnt", {p_gnt0, p_gnt1}, 2'b10);
            tick();
            tick();
            chk("tie_done", {done0, done1}, {~ew, ew});
            chk("tie_rdata", ew ? rdata1 : rdata0, ew ? 16'h00AA : 16'hBEEF);
            chk("pri_done", {p_done0, p_done1}, 2'b10);
            tick();
            chk("tie_idle", {done0, done1, gnt0, gnt1}, 0);
        end
        req0 = 0; req1 = 0;

        // Address latched at grant
        tick();
        req0 = 1; addr0 = 20'h00020;
        tick(); chk("lat_t1_addr", m_addr, 20'h00020);
        addr0 = 20'h00040;
        tick(); chk("lat_t2_addr", m_addr, 20'h00020);
        tick(); chk("lat_done", done0, 1); chk("lat_rdata", rdata0, 16'h00AA);
        req0 = 0;
        tick();

        // Reset during first ACCESS cycle of a write
        req1 = 1; we1 = 1; addr1 = 20'h00040; wdata1 = 16'hDEAD;
        tick(); chk("mr_t1_we", {we_n, doe}, 2'b01);
        rst = 1; req1 = 0; we1 = 0;
        tick(); chk("mr_strobes", {we_n, doe, ce_n}, 3'b101); chk("mr_gd", {gnt1, done1}, 0);
        rst = 0;
        tick(); chk("mr_nodone", {done0, done1, gnt0, gnt1}, 0);
        tick(); chk("mr_mem", mem[16'h0040], 16'h5555);

        // ACCESS_CYCLES=1: Done at t0+2, back-to-back every 3 cycles
        a_req0 = 1;
        tick(); chk("a1_t1_oe", a_oe, 0); chk("a1_t1_done", a_done0, 0);
        tick(); chk("a1_t2_done", a_done0, 1); chk("a1_rdata", a_rd0, 16'h5A5D);
        tick(); chk("a1_t3_done", a_done0, 0); chk("a1_t3_gnt", a_gnt0, 0);
        tick(); chk("a1_t4_oe", a_oe, 0);
        tick(); chk("a1_t5_done", a_done0, 1);
        a_req0 = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
